// File: rtl/alu_op_sequencer.sv
// Host-facing sequencer for a registered ALU: accepts one op, waits out ALU latency, returns result.
// Latency: capture at accept edge + ALU_LATENCY + 1; result held until res_ready (no in_ready bypass).
module alu_op_sequencer #(
  parameter int ALU_LATENCY = 1,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

  logic [1:0] state;
  logic [3:0] cnt;

  assign in_ready  = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_data   <= '0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Operands stay frozen until the next accept so the ALU sees stable inputs.
            alu_opcode <= in_opcode;
            alu_b      <= in_b;
            alu_a      <= in_use_acc ? acc : in_a;
            cnt        <= LAT_INIT;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            res_data <= alu_out;
            acc      <= alu_out;
            op_count <= op_count + 8'd1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table vectors, backpressure, mid-op reset, and random chained ops vs a model.
module tb_alu_op_sequencer;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_use_acc;
  logic [3:0] in_opcode, alu_opcode;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_out, res_data, acc, op_count;
  logic       res_valid, res_ready, busy;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] m_acc;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LATENCY(LAT), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .acc(acc), .busy(busy), .op_count(op_count)
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0100: return a + b;
      4'b0101: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Registered ALU with LAT pipeline stages.
  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_fn(alu_opcode, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_out = pipe[LAT-1];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one op at posedge+1; optionally hold res_ready low and pulse in_valid meanwhile.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic [7:0] exp, input int hold, input bit pulse);
    logic [7:0] ea;
    int n;
    ea = ua ? m_acc : a;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_before_op", 8'(in_ready), 8'd1);
    in_opcode = op; in_a = a; in_b = b; in_use_acc = ua; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b;
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, b);
    check("alu_opcode", 8'(alu_opcode), 8'(op));
    check("busy_wait", 8'(busy), 8'd1);
    check("in_ready_wait", 8'(in_ready), 8'd0);
    n = 0;
    while (!res_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("latency", 8'(n), 8'(LAT + 1));
    m_acc = exp;
    m_cnt = m_cnt + 8'd1;
    check("res_data", res_data, exp);
    check("acc", acc, exp);
    check("op_count", op_count, m_cnt);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        in_valid = (i >= 2 && i < 6);
        in_opcode = 4'b0100; in_a = 8'h5A; in_b = 8'h11; in_use_acc = 1'b0;
      end
      @(posedge clk); #1;
      check("bp_res_valid", 8'(res_valid), 8'd1);
      check("bp_res_data", res_data, exp);
      check("bp_in_ready", 8'(in_ready), 8'd0);
      check("bp_alu_a", alu_a, ea);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_drop", 8'(res_valid), 8'd0);
    check("in_ready_idle", 8'(in_ready), 8'd1);
    check("acc_hold", acc, exp);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ua;
    logic [7:0] exp;
    int         hold;
    bit         pulse;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [3:0] rop;
    logic [7:0] ra, rb, rexp;
    logic       rua;

    vecs[0] = '{4'b0100, 8'h01, 8'h01, 1'b0, 8'h02, 0, 1'b0};
    vecs[1] = '{4'b0100, 8'hFF, 8'h03, 1'b1, 8'h05, 10, 1'b1};
    vecs[2] = '{4'b0100, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 1'b0};
    vecs[3] = '{4'b0101, 8'h77, 8'h03, 1'b1, 8'hFD, 0, 1'b0};
    vecs[4] = '{4'b0000, 8'hF0, 8'h3C, 1'b0, 8'h30, 2, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_use_acc = 1'b0;
    in_opcode = '0; in_a = '0; in_b = '0;
    m_acc = '0; m_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_acc", acc, 8'h00);
    check("rst_op_count", op_count, 8'h00);
    check("rst_res_data", res_data, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].exp, vecs[i].hold, vecs[i].pulse);

    // Reset asserted while the ALU result is still pending.
    in_opcode = 4'b0100; in_a = 8'h40; in_b = 8'h02; in_use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy", 8'(busy), 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 8'(in_ready), 8'd1);
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_res_valid", 8'(res_valid), 8'd0);
    check("mid_rst_acc", acc, 8'h00);
    check("mid_rst_op_count", op_count, 8'h00);
    check("mid_rst_alu_a", alu_a, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = '0; m_cnt = '0;
    @(posedge clk); #1;
    run_op(4'b0100, 8'h10, 8'h20, 1'b0, 8'h30, 0, 1'b0);

    // 255 further random ops bring the completed count to 256, i.e. wrapped to 0.
    for (int k = 0; k < 255; k++) begin
      rop = 4'($urandom_range(0, 5));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rua = 1'($urandom);
      rexp = alu_fn(rop, rua ? m_acc : ra, rb);
      run_op(rop, ra, rb, rua, rexp, $urandom_range(0, 2), 1'b0);
    end
    check("op_count_wrap", op_count, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
